// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue feeding the IF/ID register.
// Owns the fetch PC, reads one word per cycle into a circular FIFO of
// {instr, pc} entries, and presents the oldest entry to decode.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (zero-latency bypass of
// the incoming imem word while the queue is empty).
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       deq,
  output logic                       out_valid,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_pcplus4,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [31:0]   fetch_pc;

  logic stored_valid;
  logic byp_active;
  logic byp_take;
  logic push;
  logic pop;

  assign stored_valid = (count != '0);
  assign full         = (count == CW'(DEPTH));
  assign imem_addr    = fetch_pc;

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue with fetch running: the live imem word is shown directly.
  assign byp_active = ~stored_valid & en & ~redirect;
  // A bypassed word taken by decode never enters storage.
  assign byp_take   = byp_active & deq;
`else
  assign byp_active = 1'b0;
  assign byp_take   = 1'b0;
`endif

  // A push into a full queue is allowed only when the head leaves this cycle.
  assign push = en & ~redirect & ~byp_take & (~full | (deq & stored_valid));
  // Pops only ever come from stored entries; deq on an empty queue is ignored.
  assign pop  = deq & stored_valid & ~redirect;

  // Head presentation: stored head entry, or the live word while bypassing.
  always_comb begin
    out_valid = stored_valid;
    out_instr = instr_q[head];
    out_pc    = pc_q[head];
    if (byp_active) begin
      out_valid = 1'b1;
      out_instr = imem_rdata;
      out_pc    = fetch_pc;
    end
    out_pcplus4 = out_pc + 32'd4;
  end

  // Control state: fetch PC, pointers and occupancy; redirect wins over all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (push || byp_take) fetch_pc <= fetch_pc + 32'd4;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage: cleared on reset so the empty head reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (push) begin
      instr_q[tail] <= imem_rdata;
      pc_q[tail]    <= fetch_pc;
    end
  end

endmodule
